// File: rtl/plugboard_config_ctrl.sv
// plugboard_config_ctrl: keystroke-programmed letter swap table with bulk clear and one-cycle lookup
module plugboard_config_ctrl #(
   parameter int MAX_PAIRS = 10
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic       i_config_mode,
   input  logic       i_key_valid,
   input  logic [4:0] i_keyboardbutton,
   input  logic       i_clear_all,
   input  logic       i_lookup_valid,
   input  logic [4:0] i_lookup_in,
   output logic [4:0] o_lookup_out,
   output logic       o_lookup_out_valid,
   output logic [3:0] o_pair_count,
   output logic       o_pending,
   output logic       o_busy,
   output logic       o_error
);
   typedef enum logic [1:0] {WAIT_FIRST, WAIT_SECOND, CLEARING} state_t;
   state_t     r_state;
   logic [4:0] r_map [26];
   logic [4:0] r_first;
   logic [4:0] r_idx;
   logic [4:0] r_lookup_out;
   logic [3:0] r_pair_count;
   logic       r_error;
   logic       r_lookup_out_valid;
   logic       w_key;
   logic       w_code_free;
   assign w_key       = i_key_valid && i_config_mode && r_state != CLEARING;
   assign w_code_free = i_keyboardbutton <= 5'd25 && r_map[i_keyboardbutton] == i_keyboardbutton;
   assign o_lookup_out       = r_lookup_out;
   assign o_lookup_out_valid = r_lookup_out_valid;
   assign o_pair_count       = r_pair_count;
   assign o_pending          = r_state == WAIT_SECOND;
   assign o_busy             = r_state == CLEARING;
   assign o_error            = r_error;
   // pairing FSM: latches first letter, writes both table entries on the second, sweeps table back to identity on clear
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_state      <= WAIT_FIRST;
         r_first      <= '0;
         r_idx        <= '0;
         r_pair_count <= '0;
         r_error      <= 1'b0;
         for (int i = 0; i < 26; i++) r_map[i] <= 5'(i);
      end else begin
         r_error <= 1'b0;
         case (r_state)
            WAIT_FIRST: begin
               if (i_clear_all) begin
                  r_state <= CLEARING;
                  r_idx   <= '0;
               end else if (w_key) begin
                  if (!w_code_free || r_pair_count == 4'(MAX_PAIRS)) r_error <= 1'b1;
                  else begin
                     r_first <= i_keyboardbutton;
                     r_state <= WAIT_SECOND;
                  end
               end
            end
            WAIT_SECOND: begin
               if (i_clear_all) begin
                  r_state <= CLEARING;
                  r_idx   <= '0;
               end else if (!i_config_mode) r_state <= WAIT_FIRST;
               else if (w_key) begin
                  if (i_keyboardbutton == r_first) r_state <= WAIT_FIRST;
                  else if (!w_code_free) r_error <= 1'b1;
                  else begin
                     r_map[r_first]          <= i_keyboardbutton;
                     r_map[i_keyboardbutton] <= r_first;
                     r_pair_count            <= r_pair_count + 4'd1;
                     r_state                 <= WAIT_FIRST;
                  end
               end
            end
            default: begin
               r_map[r_idx] <= r_idx;
               if (r_idx == 5'd25) begin
                  r_pair_count <= '0;
                  r_state      <= WAIT_FIRST;
               end else r_idx <= r_idx + 5'd1;
            end
         endcase
      end
   end
   // lookup reads the table as held before this edge's write; out-of-range or mid-clear lookups pass through
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_lookup_out_valid <= 1'b0;
         r_lookup_out       <= '0;
      end else begin
         r_lookup_out_valid <= i_lookup_valid;
         if (i_lookup_valid)
            r_lookup_out <= (i_lookup_in > 5'd25 || r_state == CLEARING) ? i_lookup_in : r_map[i_lookup_in];
      end
   end
endmodule

// File: tb/tb_plugboard_config_ctrl.sv
// tb_plugboard_config_ctrl: directed and random checks against a partner-array plugboard model
module tb_plugboard_config_ctrl;
   localparam int MAXP = 10;
   logic       clk = 1'b0;
   logic       rn = 1'b0, cm = 1'b1, kv = 1'b0, ca = 1'b0, lv = 1'b0;
   logic [4:0] kb = '0, lin = '0;
   logic [4:0] lo;
   logic       lov, pend, busy, err;
   logic [3:0] pc;
   int pm [26];
   int first, clr, eo, ev, ee;
   int n_vec = 0, n_err = 0;
   plugboard_config_ctrl #(.MAX_PAIRS(MAXP)) dut (
      .i_clock(clk), .i_resetn(rn), .i_config_mode(cm), .i_key_valid(kv),
      .i_keyboardbutton(kb), .i_clear_all(ca), .i_lookup_valid(lv), .i_lookup_in(lin),
      .o_lookup_out(lo), .o_lookup_out_valid(lov), .o_pair_count(pc),
      .o_pending(pend), .o_busy(busy), .o_error(err)
   );
   always #5 clk = ~clk;
   function automatic int pairs();
      int n = 0;
      for (int i = 0; i < 26; i++) if (pm[i] != i) n++;
      return n / 2;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask
   task automatic model();
      int k = int'(kb);
      ee = 0;
      if (!rn) begin
         for (int i = 0; i < 26; i++) pm[i] = i;
         first = -1; clr = 0; eo = 0; ev = 0;
         return;
      end
      ev = int'(lv);
      if (lv) eo = (lin > 25 || clr > 0) ? int'(lin) : pm[lin];
      if (clr > 0) begin
         clr--;
         if (clr == 0) for (int i = 0; i < 26; i++) pm[i] = i;
      end else if (ca) begin
         clr = 26; first = -1;
      end else if (first >= 0 && !cm) first = -1;
      else if (kv && cm) begin
         if (first < 0) begin
            if (k > 25 || pm[k] != k || pairs() == MAXP) ee = 1;
            else first = k;
         end else if (k == first) first = -1;
         else if (k > 25 || pm[k] != k) ee = 1;
         else begin
            pm[first] = k; pm[k] = first; first = -1;
         end
      end
   endtask
   task automatic tick();
      model();
      @(posedge clk);
      #1;
      chk("lookup_valid", lov, ev);
      chk("lookup_out", lo, eo);
      chk("pair_count", pc, pairs());
      chk("pending", pend, first >= 0);
      chk("busy", busy, clr > 0);
      chk("error", err, ee);
   endtask
   task automatic key(input int c);
      kv = 1'b1; kb = 5'(c); tick(); kv = 1'b0;
   endtask
   task automatic look(input int x);
      lv = 1'b1; lin = 5'(x); tick(); lv = 1'b0;
   endtask
   task automatic clear_now();
      ca = 1'b1; tick(); ca = 1'b0;
      for (int i = 0; i < 26; i++) tick();
   endtask
   initial begin
      rn = 1'b0; tick(); rn = 1'b1;
      chk("reset_count", pc, 0);
      key(0); key(16);
      chk("a_q_count", pc, 1);
      look(0); chk("a_q_lk0", lo, 16);
      look(16); chk("a_q_lk16", lo, 0);
      look(5); chk("a_q_lk5", lo, 5);
      key(0); chk("reuse_first_err", err, 1); chk("reuse_first_pend", pend, 0);
      tick(); chk("err_one_cycle", err, 0);
      key(1); key(16); chk("reuse_second_err", err, 1); chk("reuse_second_pend", pend, 1);
      key(1); chk("cancel_b", pend, 0);
      clear_now();
      key(2); key(2); chk("cancel_c_pend", pend, 0); chk("cancel_c_err", err, 0);
      for (int p = 0; p < MAXP; p++) begin key(2 * p); key(2 * p + 1); end
      chk("cap_count", pc, 10);
      key(20); chk("cap_err", err, 1); chk("cap_hold", pc, 10);
      clear_now();
      key(3); key(7); key(8); key(12); key(20); key(25);
      ca = 1'b1; tick(); ca = 1'b0;
      for (int i = 0; i < 26; i++) begin
         chk("clear_busy", busy, 1);
         kv = 1'b1; kb = 5'(i); lv = 1'b1; lin = 5'(25 - i); tick();
      end
      kv = 1'b0; lv = 1'b0;
      chk("clear_done", busy, 0); chk("clear_count", pc, 0);
      for (int i = 0; i < 26; i++) look(i);
      key(4); key(9);
      ca = 1'b1; tick(); ca = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      rn = 1'b0; tick(); rn = 1'b1;
      chk("rst_clr_busy", busy, 0); chk("rst_clr_count", pc, 0);
      key(6); key(11); key(13);
      lv = 1'b1; lin = 5'd6; rn = 1'b0; tick(); rn = 1'b1; lv = 1'b0;
      chk("rst_ws_pend", pend, 0); chk("rst_ws_valid", lov, 0); chk("rst_ws_count", pc, 0);
      for (int i = 0; i < 26; i++) look(i);
      key(27); chk("invalid_err", err, 1);
      cm = 1'b0; key(5); chk("mode_err", err, 0); chk("mode_pend", pend, 0); cm = 1'b1;
      look(30); chk("lookup30", lo, 30);
      for (int n = 0; n < 3000; n++) begin
         rn = ($urandom % 300) != 0;
         cm = ($urandom % 10) != 0;
         kv = ($urandom % 3) != 0;
         kb = ($urandom % 8 == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
         ca = ($urandom % 150) == 0;
         lv = $urandom % 2;
         lin = 5'($urandom);
         tick();
      end
      rn = 1'b1; kv = 1'b0; ca = 1'b0; lv = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
